// File: rtl/line_window_3x3.sv
// Streaming 3x3 neighbourhood generator.
// Raster-order pixels go in. Two line buffers hold the previous two rows.
// One 3x3 window comes out for every fully interior centre pixel.
module line_window_3x3 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pixel,
    input  logic                  in_sof,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [9*DATA_W-1:0]   window_out,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_eof
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0]    col;
    logic [ROW_W-1:0]    row;
    logic [COL_W-1:0]    eff_col;
    logic [ROW_W-1:0]    eff_row;
    logic                accept;
    logic                emit;
    logic [DATA_W-1:0]   lb0 [IMG_W];
    logic [DATA_W-1:0]   lb1 [IMG_W];
    logic [DATA_W-1:0]   lb0_rd;
    logic [DATA_W-1:0]   lb1_rd;
    logic [DATA_W-1:0]   top [3];
    logic [DATA_W-1:0]   mid [3];
    logic [DATA_W-1:0]   bot [3];
    logic [9*DATA_W-1:0] win_next;
    logic                sof_next;
    logic                eol_next;
    logic                eof_next;

    assign in_ready = !out_valid || out_ready;

    // Accept, effective position (in_sof forces (0,0)), line-buffer reads and window assembly.
    always_comb begin
        accept   = in_valid && in_ready;
        eff_col  = in_sof ? '0 : col;
        eff_row  = in_sof ? '0 : row;
        lb0_rd   = lb0[eff_col];
        lb1_rd   = lb1[eff_col];
        emit     = accept && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
        // Lane 0 sits in the LSBs; each row runs left to right, oldest tap first.
        win_next = {in_pixel, bot[2], bot[1],
                    lb0_rd,   mid[2], mid[1],
                    lb1_rd,   top[2], top[1]};
        sof_next = (eff_row == ROW_W'(2)) && (eff_col == COL_W'(2));
        eol_next = (eff_col == COL_LAST);
        eof_next = eol_next && (eff_row == ROW_LAST);
    end

    // Raster position of the next pixel; it wraps at the end of a row and at the end of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (eff_col == COL_LAST) begin
                col <= '0;
                row <= (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col <= eff_col + 1'b1;
                row <= eff_row;
            end
        end
    end

    // Line buffers: the previous row moves into lb1 and the new pixel goes into lb0. They are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[eff_col] <= lb0_rd;
            lb0[eff_col] <= in_pixel;
        end
    end

    // Tap rows shift left on every accept and take the newest column on the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 3; i++) begin
                top[i] <= '0;
                mid[i] <= '0;
                bot[i] <= '0;
            end
        end else if (accept) begin
            top[0] <= top[1];
            top[1] <= top[2];
            top[2] <= lb1_rd;
            mid[0] <= mid[1];
            mid[1] <= mid[2];
            mid[2] <= lb0_rd;
            bot[0] <= bot[1];
            bot[1] <= bot[2];
            bot[2] <= in_pixel;
        end
    end

    // Output register: load on an emitting accept, clear when consumed, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            window_out <= '0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_eof    <= 1'b0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            window_out <= win_next;
            out_sof    <= sof_next;
            out_eol    <= eol_next;
            out_eof    <= eof_next;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_window_3x3.sv
// Testbench for line_window_3x3 on a 5x4 frame.
// A frame-array reference model predicts every window.
module tb_line_window_3x3;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int VW = 9*DW + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_sof = 1'b0;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   in_pixel = '0;
    logic            in_ready;
    logic            out_valid;
    logic [9*DW-1:0] window_out;
    logic            out_sof;
    logic            out_eol;
    logic            out_eof;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] frame [H][W];
    int            mr = 0;
    int            mc = 0;
    logic [VW-1:0] expq [$];
    logic [VW-1:0] base_win [6];

    line_window_3x3 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .window_out(window_out),
        .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: store the pixel at its frame position and queue the window it completes.
    task automatic model_accept(input logic [DW-1:0] pix, input logic sf);
        logic [VW-1:0] v;
        if (sf) begin mr = 0; mc = 0; end
        frame[mr][mc] = pix;
        if (mr >= 2 && mc >= 2) begin
            v = '0;
            for (int dr = 0; dr < 3; dr++)
                for (int dc = 0; dc < 3; dc++)
                    v[(dr*3+dc)*DW +: DW] = frame[mr-2+dr][mc-2+dc];
            v[VW-3] = (mr == 2 && mc == 2);
            v[VW-2] = (mc == W-1);
            v[VW-1] = (mr == H-1 && mc == W-1);
            expq.push_back(v);
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        expq.delete();
    endtask

    function automatic logic [DW-1:0] pix10(input int p);
        return DW'(10*(p/W) + p%W);
    endfunction

    // Window of a 10*r+c frame whose top-left pixel value is base.
    function automatic logic [VW-1:0] mk_win(input int base, input logic [2:0] fl);
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(base + 10*(k/3) + k%3);
        v[VW-1 -: 3] = fl;
        return v;
    endfunction

    // One clock: drive the inputs at the falling edge, then sample the handshakes and outputs.
    task automatic step(input logic iv, input logic [DW-1:0] pix, input logic sf, input logic ordy,
                        output logic acc, output logic cons, output logic ov, output logic ir,
                        output logic [VW-1:0] obs, output logic [VW-1:0] expv, output logic have);
        @(negedge clk);
        in_valid = iv; in_pixel = pix; in_sof = sf; out_ready = ordy;
        #1;
        ir = in_ready;
        ov = out_valid;
        acc = in_valid && in_ready;
        cons = out_valid && out_ready;
        obs = {out_eof, out_eol, out_sof, window_out};
        have = 1'b0;
        expv = '0;
        if (cons && expq.size() > 0) begin expv = expq.pop_front(); have = 1'b1; end
        if (acc) model_accept(pix, sf);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++;
        if (window_out !== '0) begin errors++; $display("FAIL reset_window got=%h exp=0", window_out); end
        checks++;
        if ({out_sof, out_eol, out_eof} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b exp=000", {out_sof, out_eol, out_eof});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic acc, cons, ov, ir, have;
        logic [VW-1:0] obs, expv, last_obs;
        int p = 0, nwin = 0, neol = 0;
        last_obs = '0;
        for (int cyc = 0; cyc < 40 && (p < W*H || expq.size() > 0 || out_valid); cyc++) begin
            step(p < W*H, pix10(p), 1'b0, 1'b1, acc, cons, ov, ir, obs, expv, have);
            if (acc) p++;
            if (cons) begin
                checks++;
                if (!have || obs !== expv) begin errors++; $display("FAIL basic_win idx=%0d got=%h exp=%h", nwin, obs, expv); end
                if (nwin == 0) begin
                    checks++;
                    if (obs !== mk_win(0, 3'b001)) begin errors++; $display("FAIL basic_first got=%h exp=%h", obs, mk_win(0, 3'b001)); end
                end
                if (nwin < 6) base_win[nwin] = expv;
                if (obs[VW-2]) neol++;
                last_obs = obs;
                nwin++;
            end
        end
        checks++;
        if (nwin != 6) begin errors++; $display("FAIL basic_count got=%0d exp=6", nwin); end
        checks++;
        if (neol != 2) begin errors++; $display("FAIL basic_eol_count got=%0d exp=2", neol); end
        checks++;
        if (last_obs !== mk_win(12, 3'b110)) begin errors++; $display("FAIL basic_last got=%h exp=%h", last_obs, mk_win(12, 3'b110)); end
        checks++;
        if (expq.size() != 0) begin errors++; $display("FAIL basic_pending got=%0d exp=0", expq.size()); end
    endtask

    task automatic test_stall();
        logic acc, cons, ov, ir, have, ordy, stalled;
        logic [VW-1:0] obs, expv, held;
        int p = 0, nwin = 0, stall_left = 0;
        stalled = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 60 && (p < W*H || expq.size() > 0 || out_valid); cyc++) begin
            ordy = (stall_left > 0) ? 1'b0 : 1'b1;
            step(p < W*H, pix10(p), 1'b0, ordy, acc, cons, ov, ir, obs, expv, have);
            if (stall_left > 0) begin
                checks++;
                if (ir !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", ir); end
                if (stall_left == 3) held = obs;
                else begin
                    checks++;
                    if (obs !== held) begin errors++; $display("FAIL stall_hold got=%h exp=%h", obs, held); end
                end
                stall_left--;
            end
            if (acc) p++;
            if (cons) begin
                checks++;
                if (!have || obs !== expv) begin errors++; $display("FAIL stall_win idx=%0d got=%h exp=%h", nwin, obs, expv); end
                nwin++;
            end
            if (nwin == 2 && !stalled) begin stalled = 1'b1; stall_left = 3; end
        end
        checks++;
        if (nwin != 6 || !stalled) begin errors++; $display("FAIL stall_count got=%0d exp=6", nwin); end
        checks++;
        if (expq.size() != 0) begin errors++; $display("FAIL stall_pending got=%0d exp=0", expq.size()); end
    endtask

    task automatic test_back_to_back();
        logic acc, cons, ov, ir, have;
        logic [VW-1:0] obs, expv;
        logic [DW-1:0] rf [W*H];
        int p = 0, nwin = 0, nsof = 0;
        for (int i = 0; i < W*H; i++) rf[i] = DW'($urandom);
        for (int cyc = 0; cyc < 70 && (p < 2*W*H || expq.size() > 0 || out_valid); cyc++) begin
            step(p < 2*W*H, rf[p % (W*H)], 1'b0, 1'b1, acc, cons, ov, ir, obs, expv, have);
            if (acc) p++;
            if (cons) begin
                checks++;
                if (!have || obs !== expv) begin errors++; $display("FAIL b2b_win idx=%0d got=%h exp=%h", nwin, obs, expv); end
                if (nwin == 6) begin
                    checks++;
                    if (obs[VW-3] !== 1'b1) begin errors++; $display("FAIL b2b_second_sof got=%b exp=1", obs[VW-3]); end
                end
                if (obs[VW-3]) nsof++;
                nwin++;
            end
        end
        checks++;
        if (nwin != 12 || nsof != 2) begin errors++; $display("FAIL b2b_count got=%0d/%0d exp=12/2", nwin, nsof); end
    endtask

    task automatic test_resync();
        logic acc, cons, ov, ir, have, sof_seen, first_ov, first_win;
        logic [VW-1:0] obs, expv;
        logic [DW-1:0] pix;
        int p = 0, n_since = 0, npost = 0;
        sof_seen = 1'b0; first_ov = 1'b0; first_win = 1'b0;
        for (int cyc = 0; cyc < 80 && (p < 34 || expq.size() > 0 || out_valid); cyc++) begin
            pix = (p < 13) ? pix10(p) : DW'(100 + p - 13);
            step(p < 34, pix, p == 13, 1'b1, acc, cons, ov, ir, obs, expv, have);
            if (sof_seen && ov && !first_ov) begin
                first_ov = 1'b1;
                checks++;
                if (n_since != 13) begin errors++; $display("FAIL resync_latency got=%0d exp=13", n_since); end
            end
            if (cons) begin
                checks++;
                if (!have || obs !== expv) begin errors++; $display("FAIL resync_win got=%h exp=%h", obs, expv); end
                if (sof_seen) begin
                    if (!first_win) begin
                        first_win = 1'b1;
                        checks++;
                        if (obs[VW-3] !== 1'b1) begin errors++; $display("FAIL resync_sof got=%b exp=1", obs[VW-3]); end
                        for (int k = 0; k < 9; k++) begin
                            checks++;
                            if (obs[k*DW +: DW] < DW'(100)) begin
                                errors++; $display("FAIL resync_lane%0d got=%0d exp>=100", k, obs[k*DW +: DW]);
                            end
                        end
                    end
                    npost++;
                end
            end
            if (acc) begin
                if (p == 13) sof_seen = 1'b1;
                if (sof_seen) n_since++;
                p++;
            end
        end
        checks++;
        if (npost != 6) begin errors++; $display("FAIL resync_count got=%0d exp=6", npost); end
    endtask

    task automatic test_rst_mid();
        logic acc, cons, ov, ir, have;
        logic [VW-1:0] obs, expv;
        int p = 0, nwin = 0;
        for (int cyc = 0; cyc < 30 && p < 13; cyc++) begin
            step(1'b1, pix10(p), 1'b0, 1'b1, acc, cons, ov, ir, obs, expv, have);
            if (acc) p++;
        end
        step(1'b0, '0, 1'b0, 1'b0, acc, cons, ov, ir, obs, expv, have);
        checks++;
        if (ov !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", ov); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_valid got=%b exp=0", out_valid); end
        checks++;
        if (window_out !== '0) begin errors++; $display("FAIL rstmid_window got=%h exp=0", window_out); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        p = 0;
        for (int cyc = 0; cyc < 40 && (p < W*H || expq.size() > 0 || out_valid); cyc++) begin
            step(p < W*H, pix10(p), 1'b0, 1'b1, acc, cons, ov, ir, obs, expv, have);
            if (acc) p++;
            if (cons) begin
                checks++;
                if (!have || obs !== expv) begin errors++; $display("FAIL rstmid_win idx=%0d got=%h exp=%h", nwin, obs, expv); end
                nwin++;
            end
        end
        checks++;
        if (nwin != 6) begin errors++; $display("FAIL rstmid_count got=%0d exp=6", nwin); end
    endtask

    task automatic test_toggle();
        logic acc, cons, ov, ir, have, ordy;
        logic [VW-1:0] obs, expv;
        int p = 0, nwin = 0;
        for (int cyc = 0; cyc < 300 && (p < W*H || expq.size() > 0 || out_valid); cyc++) begin
            ordy = 1'($urandom_range(0, 1));
            step((cyc % 2 == 0) && (p < W*H), pix10(p), 1'b0, ordy, acc, cons, ov, ir, obs, expv, have);
            if (acc) p++;
            if (cons) begin
                checks++;
                if (!have || obs !== expv || nwin >= 6 || obs !== base_win[nwin % 6]) begin
                    errors++; $display("FAIL toggle_win idx=%0d got=%h exp=%h", nwin, obs, base_win[nwin % 6]);
                end
                nwin++;
            end
        end
        checks++;
        if (nwin != 6) begin errors++; $display("FAIL toggle_count got=%0d exp=6", nwin); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_resync();
        test_rst_mid();
        test_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
